// File: rtl/busca_instrucao.sv
// Instruction fetch stage: fetches words over a req/ready handshake, holds each one
// until decode accepts it, and drives registered slices to the immediate sign-extender.
module busca_instrucao #(
    parameter int unsigned           LARGURA_PC = 16,
    parameter logic [LARGURA_PC-1:0] PC_INICIAL = '0
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  habilita,
    output logic                  mem_req,
    output logic [LARGURA_PC-1:0] mem_endereco,
    input  logic                  mem_pronto,
    input  logic [31:0]           mem_dado,
    input  logic                  desvio,
    input  logic [LARGURA_PC-1:0] endereco_desvio,
    input  logic                  avancar,
    output logic                  instrucao_valida,
    output logic [31:0]           instrucao,
    output logic [LARGURA_PC-1:0] pc_instrucao,
    output logic [16:0]           entrada_1,
    output logic [21:0]           entrada_2,
    output logic                  selecao
);

    typedef enum logic [1:0] {
        OCIOSO,
        BUSCA,
        ENTREGA,
        DESCARTE
    } estado_t;

    estado_t               estado_q, estado_d;
    logic [LARGURA_PC-1:0] pc_q, pc_d;
    logic                  mem_req_q, mem_req_d;
    logic [LARGURA_PC-1:0] mem_endereco_q, mem_endereco_d;
    logic                  valida_q, valida_d;
    logic [31:0]           instrucao_q, instrucao_d;
    logic [LARGURA_PC-1:0] pc_instrucao_q, pc_instrucao_d;
    logic [16:0]           entrada_1_q, entrada_1_d;
    logic [21:0]           entrada_2_q, entrada_2_d;
    logic                  selecao_q, selecao_d;

    always_comb begin
        estado_d       = estado_q;
        pc_d           = pc_q;
        mem_req_d      = mem_req_q;
        mem_endereco_d = mem_endereco_q;
        valida_d       = valida_q;
        instrucao_d    = instrucao_q;
        pc_instrucao_d = pc_instrucao_q;
        entrada_1_d    = entrada_1_q;
        entrada_2_d    = entrada_2_q;
        selecao_d      = selecao_q;

        case (estado_q)
            OCIOSO: begin
                if (desvio) pc_d = endereco_desvio;
                if (habilita) begin
                    estado_d       = BUSCA;
                    mem_req_d      = 1'b1;
                    mem_endereco_d = pc_d;
                end
            end

            BUSCA: begin
                if (desvio) begin
                    pc_d = endereco_desvio;
                    // A completed access is dropped and the target requested back-to-back;
                    // an outstanding one must still be drained before re-issuing.
                    if (mem_pronto) begin
                        estado_d       = BUSCA;
                        mem_endereco_d = endereco_desvio;
                    end else begin
                        estado_d = DESCARTE;
                    end
                end else if (mem_pronto) begin
                    instrucao_d    = mem_dado;
                    pc_instrucao_d = pc_q;
                    entrada_1_d    = mem_dado[16:0];
                    entrada_2_d    = mem_dado[21:0];
                    selecao_d      = &mem_dado[31:30];
                    pc_d           = pc_q + LARGURA_PC'(1);
                    mem_req_d      = 1'b0;
                    valida_d       = 1'b1;
                    estado_d       = ENTREGA;
                end
            end

            ENTREGA: begin
                if (desvio || avancar) begin
                    if (desvio) pc_d = endereco_desvio;
                    valida_d = 1'b0;
                    if (habilita) begin
                        estado_d       = BUSCA;
                        mem_req_d      = 1'b1;
                        mem_endereco_d = pc_d;
                    end else begin
                        estado_d = OCIOSO;
                    end
                end
            end

            DESCARTE: begin
                if (desvio) pc_d = endereco_desvio;
                if (mem_pronto) begin
                    estado_d       = BUSCA;
                    mem_endereco_d = pc_d;
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado_q       <= OCIOSO;
            pc_q           <= PC_INICIAL;
            mem_req_q      <= 1'b0;
            mem_endereco_q <= PC_INICIAL;
            valida_q       <= 1'b0;
            instrucao_q    <= '0;
            pc_instrucao_q <= '0;
            entrada_1_q    <= '0;
            entrada_2_q    <= '0;
            selecao_q      <= 1'b0;
        end else begin
            estado_q       <= estado_d;
            pc_q           <= pc_d;
            mem_req_q      <= mem_req_d;
            mem_endereco_q <= mem_endereco_d;
            valida_q       <= valida_d;
            instrucao_q    <= instrucao_d;
            pc_instrucao_q <= pc_instrucao_d;
            entrada_1_q    <= entrada_1_d;
            entrada_2_q    <= entrada_2_d;
            selecao_q      <= selecao_d;
        end
    end

    assign mem_req          = mem_req_q;
    assign mem_endereco     = mem_endereco_q;
    assign instrucao_valida = valida_q;
    assign instrucao        = instrucao_q;
    assign pc_instrucao     = pc_instrucao_q;
    assign entrada_1        = entrada_1_q;
    assign entrada_2        = entrada_2_q;
    assign selecao          = selecao_q;

endmodule

// File: tb/tb_busca_instrucao.sv
// Scoreboard bench for busca_instrucao: stimulus queues expected deliveries, a monitor
// pops and compares on every accepted instruction; a second instance covers PC wrap and reset.
module tb_busca_instrucao;

    logic        clock = 1'b0;
    always #5 clock = ~clock;

    // Instance A: PC starts at 0, memory with programmable wait states.
    logic        reset_n, habilita, mem_req, mem_pronto, desvio, avancar;
    logic        instrucao_valida, selecao;
    logic [15:0] mem_endereco, endereco_desvio, pc_instrucao;
    logic [31:0] mem_dado, instrucao;
    logic [16:0] entrada_1;
    logic [21:0] entrada_2;

    // Instance B: PC starts at FFFF, zero-wait memory.
    logic        reset_n_b, habilita_b, mem_req_b, mem_pronto_b, avancar_b;
    logic        valida_b, selecao_b;
    logic [15:0] mem_endereco_b, pc_instrucao_b;
    logic [31:0] mem_dado_b, instrucao_b;
    logic [16:0] entrada_1_b;
    logic [21:0] entrada_2_b;

    busca_instrucao #(.LARGURA_PC(16), .PC_INICIAL(16'h0000)) dut (
        .clock(clock), .reset_n(reset_n), .habilita(habilita),
        .mem_req(mem_req), .mem_endereco(mem_endereco), .mem_pronto(mem_pronto),
        .mem_dado(mem_dado), .desvio(desvio), .endereco_desvio(endereco_desvio),
        .avancar(avancar), .instrucao_valida(instrucao_valida), .instrucao(instrucao),
        .pc_instrucao(pc_instrucao), .entrada_1(entrada_1), .entrada_2(entrada_2),
        .selecao(selecao)
    );

    busca_instrucao #(.LARGURA_PC(16), .PC_INICIAL(16'hFFFF)) dut_b (
        .clock(clock), .reset_n(reset_n_b), .habilita(habilita_b),
        .mem_req(mem_req_b), .mem_endereco(mem_endereco_b), .mem_pronto(mem_pronto_b),
        .mem_dado(mem_dado_b), .desvio(1'b0), .endereco_desvio(16'h0000),
        .avancar(avancar_b), .instrucao_valida(valida_b), .instrucao(instrucao_b),
        .pc_instrucao(pc_instrucao_b), .entrada_1(entrada_1_b), .entrada_2(entrada_2_b),
        .selecao(selecao_b)
    );

    function automatic logic [31:0] word_at(input logic [15:0] a);
        case (a)
            16'h0000: return 32'hC01F_FFFF;
            16'h0001: return 32'h0001_8000;
            default:  return {a ^ 16'hF00D, ~a};
        endcase
    endfunction

    int wait_cfg;
    int cnt;
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n)                    cnt <= 0;
        else if (mem_req && !mem_pronto) cnt <= cnt + 1;
        else                             cnt <= 0;
    end
    assign mem_pronto   = mem_req && (cnt >= wait_cfg);
    assign mem_dado     = mem_pronto ? word_at(mem_endereco) : 32'hDEAD_BEEF;
    assign mem_pronto_b = mem_req_b;
    assign mem_dado_b   = mem_pronto_b ? word_at(mem_endereco_b) : 32'hDEAD_BEEF;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    typedef struct {
        logic [15:0] pc;
        logic [31:0] w;
        logic [16:0] e1;
        logic [21:0] e2;
        logic        sel;
    } exp_t;
    exp_t sb[$];

    task automatic push_exp(input logic [15:0] pc, input logic [31:0] w,
                            input logic [16:0] e1, input logic [21:0] e2, input logic sel);
        exp_t e;
        e.pc = pc; e.w = w; e.e1 = e1; e.e2 = e2; e.sel = sel;
        sb.push_back(e);
    endtask

    task automatic push_auto(input logic [15:0] a);
        logic [31:0] w;
        w = word_at(a);
        push_exp(a, w, w[16:0], w[21:0], w[31:30] == 2'b11);
    endtask

    // Monitor: every instruction decode accepts must match the head of the scoreboard.
    always @(negedge clock) begin
        if (reset_n && instrucao_valida && avancar && !desvio) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_delivery_pc", 32'(pc_instrucao), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_instrucao", instrucao, e.w);
                check("sb_pc_instrucao", 32'(pc_instrucao), 32'(e.pc));
                check("sb_entrada_1", 32'(entrada_1), 32'(e.e1));
                check("sb_entrada_2", 32'(entrada_2), 32'(e.e2));
                check("sb_selecao", 32'(selecao), 32'(e.sel));
            end
        end
    end

    int t;
    task automatic tick();
        @(posedge clock);
        #2;
        t++;
    endtask

    task automatic wait_req(input string name);
        int n = 0;
        while (!mem_req && n < 50) begin tick(); n++; end
        check(name, 32'(mem_req), 32'h1);
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!instrucao_valida && n < 50) begin tick(); n++; end
        check(name, 32'(instrucao_valida), 32'h1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0; habilita = 1'b1; avancar = 1'b1; desvio = 1'b0;
        endereco_desvio = 16'h0000; wait_cfg = 0;
        reset_n_b = 1'b0; habilita_b = 1'b0; avancar_b = 1'b1;
        t = 0;
        tick(); tick();

        check("rst_mem_req", 32'(mem_req), 32'h0);
        check("rst_mem_endereco", 32'(mem_endereco), 32'h0);
        check("rst_valida", 32'(instrucao_valida), 32'h0);
        check("rst_instrucao", instrucao, 32'h0);
        check("rst_selecao", 32'(selecao), 32'h0);

        // Sequential zero-wait fetch, including the two extender-format vectors.
        push_exp(16'h0000, 32'hC01F_FFFF, 17'h1_FFFF, 22'h1F_FFFF, 1'b1);
        push_exp(16'h0001, 32'h0001_8000, 17'h1_8000, 22'h01_8000, 1'b0);
        push_auto(16'h0002);
        push_auto(16'h0003);
        push_auto(16'h0004);
        reset_n = 1'b1;
        t = 0;
        tick();
        check("seq_first_req", 32'(mem_req), 32'h1);
        check("seq_first_addr", 32'(mem_endereco), 32'h0);
        tick();
        // Visible during the third cycle after reset release.
        check("seq_first_valid", 32'(instrucao_valida), 32'h1);
        check("seq_jump_selecao", 32'(selecao), 32'h1);
        check("seq_jump_entrada_2", 32'(entrada_2), 32'h1F_FFFF);
        for (int k = 1; k <= 4; k++) begin
            tick();
            wait_req("seq_req_timeout");
            check("seq_req_cycle", t, 1 + 2 * k);
            check("seq_req_addr", 32'(mem_endereco), k);
        end
        habilita = 1'b0;
        repeat (4) tick();
        check("seq_halt_req", 32'(mem_req), 32'h0);
        check("seq_halt_valida", 32'(instrucao_valida), 32'h0);
        check("seq_drained", sb.size(), 0);

        // Redirect while the fetch at address 5 is still outstanding.
        wait_cfg = 2;
        habilita = 1'b1;
        push_auto(16'h0040);
        tick();
        check("desv_req_addr5", 32'(mem_endereco), 32'h5);
        desvio = 1'b1; endereco_desvio = 16'h0040;
        tick();
        desvio = 1'b0; habilita = 1'b0;
        check("desv_hold_req", 32'(mem_req), 32'h1);
        check("desv_hold_addr", 32'(mem_endereco), 32'h5);
        tick();
        check("desv_hold_addr2", 32'(mem_endereco), 32'h5);
        tick();
        check("desv_new_req", 32'(mem_req), 32'h1);
        check("desv_new_addr", 32'(mem_endereco), 32'h40);
        check("desv_no_valid", 32'(instrucao_valida), 32'h0);
        wait_valid("desv_valid_timeout");
        tick(); tick();
        check("desv_drained", sb.size(), 0);

        // Slow memory (4 wait cycles) followed by decode back-pressure.
        wait_cfg = 4;
        habilita = 1'b1;
        avancar = 1'b0;
        push_auto(16'h0041);
        tick();
        for (int i = 0; i < 5; i++) begin
            check("slow_req_held", 32'(mem_req), 32'h1);
            check("slow_addr_held", 32'(mem_endereco), 32'h41);
            habilita = 1'b0;
            tick();
        end
        check("slow_valid", 32'(instrucao_valida), 32'h1);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("stall_valida", 32'(instrucao_valida), 32'h1);
            check("stall_instrucao", instrucao, 32'hF04C_FFBE);
            check("stall_pc", 32'(pc_instrucao), 32'h41);
            check("stall_req", 32'(mem_req), 32'h0);
        end
        avancar = 1'b1;
        tick(); tick();
        check("stall_released", 32'(instrucao_valida), 32'h0);
        check("stall_drained", sb.size(), 0);

        // PC wrap from FFFF and asynchronous reset in the middle of a fetch.
        reset_n_b = 1'b1; habilita_b = 1'b1;
        tick(); tick();
        check("wrap_valid0", 32'(valida_b), 32'h1);
        check("wrap_pc0", 32'(pc_instrucao_b), 32'hFFFF);
        check("wrap_instr0", instrucao_b, 32'h0FF2_0000);
        tick(); tick();
        check("wrap_valid1", 32'(valida_b), 32'h1);
        check("wrap_pc1", 32'(pc_instrucao_b), 32'h0000);
        check("wrap_instr1", instrucao_b, 32'hC01F_FFFF);
        tick();
        check("wrap_req_addr1", 32'(mem_req_b), 32'h1);
        check("wrap_addr1", 32'(mem_endereco_b), 32'h1);
        reset_n_b = 1'b0;
        #1;
        check("arst_req", 32'(mem_req_b), 32'h0);
        check("arst_addr", 32'(mem_endereco_b), 32'hFFFF);
        check("arst_valida", 32'(valida_b), 32'h0);
        check("arst_instrucao", instrucao_b, 32'h0);
        check("arst_pc_instrucao", 32'(pc_instrucao_b), 32'h0);
        check("arst_entrada_1", 32'(entrada_1_b), 32'h0);
        check("arst_entrada_2", 32'(entrada_2_b), 32'h0);
        check("arst_selecao", 32'(selecao_b), 32'h0);

        tick();
        check("sb_empty_at_end", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
